// File: rtl/wash_pkg.sv
// Shared constants for the washing-machine controller: phase lengths in units
// and the unit-counter geometry used by wash_timer and the washing FSM.
package wash_pkg;

    localparam int unsigned UNITS_W = 3;

    localparam logic [UNITS_W-1:0] UNITS_MAX   = 3'd7;
    localparam logic [UNITS_W-1:0] FILL_UNITS  = 3'd2;
    localparam logic [UNITS_W-1:0] WASH_UNITS  = 3'd5;
    localparam logic [UNITS_W-1:0] RINSE_UNITS = 3'd2;
    localparam logic [UNITS_W-1:0] SPIN_UNITS  = 3'd1;

    localparam int unsigned FAST_SIM_CYCLES = 4;

endpackage

// File: rtl/wash_prescaler.sv
// Cycle prescaler for the wash unit-time base: counts 0..CYCLES-1 while
// enabled, with synchronous clear, and emits a registered one-cycle wrap tick.
module wash_prescaler #(
    parameter int unsigned CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap,
    output logic tick
);

    localparam int unsigned PW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;

    // Wrap is only taken on a running cycle; a stop on the wrap cycle defers it.
    assign wrap = !clear && enable && (presc == PRESC_MAX);

    always_comb begin
        presc_d = presc;
        tick_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else if (enable) begin
            if (presc == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= presc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/wash_timer.sv
// Unit-time base for the washing FSM: saturating unit counter plus done flags.
// Define WASH_TIMER_FAST_SIM_EN to shorten each unit to FAST_SIM_CYCLES clocks.
module wash_timer
    import wash_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_timer,
    input  logic               timer_stop,
    output logic               done_1u,
    output logic               done_2u,
    output logic               done_5u,
    output logic               unit_tick,
    output logic [UNITS_W-1:0] elapsed_units
);

`ifdef WASH_TIMER_FAST_SIM_EN
    localparam int unsigned EFF_CYCLES = FAST_SIM_CYCLES;
`else
    localparam int unsigned EFF_CYCLES = UNIT_CYCLES;
`endif

    logic               wrap;
    logic               clear;
    logic [UNITS_W-1:0] units;
    logic [UNITS_W-1:0] units_d;

    assign clear = !reset_timer;

    wash_prescaler #(
        .CYCLES(EFF_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .enable(!timer_stop),
        .wrap  (wrap),
        .tick  (unit_tick)
    );

    always_comb begin
        units_d = units;
        if (clear) begin
            units_d = '0;
        end else if (wrap && (units != UNITS_MAX)) begin
            units_d = units + UNITS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units <= '0;
        end else begin
            units <= units_d;
        end
    end

    assign done_1u       = (units >= SPIN_UNITS);
    assign done_2u       = (units >= FILL_UNITS);
    assign done_5u       = (units >= WASH_UNITS);
    assign elapsed_units = units;

endmodule

// File: tb/tb_wash_timer.sv
// Directed self-checking bench for wash_timer with UNIT_CYCLES = 10
// (unit length 4 when built with WASH_TIMER_FAST_SIM_EN).
module tb_wash_timer;

`ifdef WASH_TIMER_FAST_SIM_EN
    localparam int U = 4;
`else
    localparam int U = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_timer;
    logic       timer_stop;
    logic       done_1u;
    logic       done_2u;
    logic       done_5u;
    logic       unit_tick;
    logic [2:0] elapsed_units;

    int checks   = 0;
    int failures = 0;

    wash_timer #(
        .UNIT_CYCLES(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_timer  (reset_timer),
        .timer_stop   (timer_stop),
        .done_1u      (done_1u),
        .done_2u      (done_2u),
        .done_5u      (done_5u),
        .unit_tick    (unit_tick),
        .elapsed_units(elapsed_units)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] units, input logic tick);
        check({tag, ".units"}, {5'd0, elapsed_units}, {5'd0, units});
        check({tag, ".tick"}, {7'd0, unit_tick}, {7'd0, tick});
        check({tag, ".d1"}, {7'd0, done_1u}, {7'd0, units >= 3'd1});
        check({tag, ".d2"}, {7'd0, done_2u}, {7'd0, units >= 3'd2});
        check({tag, ".d5"}, {7'd0, done_5u}, {7'd0, units >= 3'd5});
    endtask

    task automatic do_clear();
        reset_timer = 1'b0;
        step(1);
        reset_timer = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        reset_timer = 1'b0;
        timer_stop  = 1'b0;
        #3;
        check_all("reset_async", 3'd0, 1'b0);
        step(3);
        check_all("reset_held", 3'd0, 1'b0);
        reset       = 1'b0;
        reset_timer = 1'b1;

        // Free run from zero.
        step(U - 1);
        check_all("pre_first_unit", 3'd0, 1'b0);
        step(1);
        check_all("first_unit", 3'd1, 1'b1);
        step(1);
        check_all("tick_one_cycle", 3'd1, 1'b0);
        step(U - 1);
        check_all("second_unit", 3'd2, 1'b1);
        step(3 * U - 1);
        check_all("pre_fifth_unit", 3'd4, 1'b0);
        step(1);
        check_all("fifth_unit", 3'd5, 1'b1);
        step(3 * U);
        check_all("sat_at_8u", 3'd7, 1'b1);
        step(1);
        check_all("sat_tick_low", 3'd7, 1'b0);
        step(U - 1);
        check_all("sat_tick_again", 3'd7, 1'b1);

        // Clear together with stop: clear wins, no effect before the edge.
        step(3);
        reset_timer = 1'b0;
        timer_stop  = 1'b1;
        #1;
        check_all("clear_pre_edge", 3'd7, 1'b0);
        step(1);
        check_all("clear_wins", 3'd0, 1'b0);
        reset_timer = 1'b1;
        timer_stop  = 1'b0;
        step(U - 1);
        check_all("after_clear_pre", 3'd0, 1'b0);
        step(1);
        check_all("after_clear_unit", 3'd1, 1'b1);

        // Stop for 7 cycles after U+3 running cycles delays done_2u by 7.
        do_clear();
        step(U + 3);
        check_all("stop_start", 3'd1, 1'b0);
        timer_stop = 1'b1;
        step(7);
        check_all("stop_frozen", 3'd1, 1'b0);
        timer_stop = 1'b0;
        step(U - 4);
        check_all("stop_pre_d2", 3'd1, 1'b0);
        step(1);
        check_all("stop_d2", 3'd2, 1'b1);

        // Stop on the wrap cycle defers the wrap to the next running cycle.
        do_clear();
        step(U - 1);
        timer_stop = 1'b1;
        step(1);
        check_all("wrap_stopped", 3'd0, 1'b0);
        timer_stop = 1'b0;
        step(1);
        check_all("wrap_deferred", 3'd1, 1'b1);

        // Async reset mid-unit, sampled between edges.
        do_clear();
        step(U + 2);
        check_all("pre_async", 3'd1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 3'd0, 1'b0);
        step(1);
        reset = 1'b0;
        step(U - 1);
        check_all("post_reset_pre", 3'd0, 1'b0);
        step(1);
        check_all("post_reset_unit", 3'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
